burst_ctrl: RTL and testbench

BURST_CTRL -- requirements
Module: burst_ctrl

---
 rtl/burst_pkg.sv | 14 +
 rtl/burst_len_cnt.sv | 42 ++++
 rtl/burst_ctrl.sv | 114 +++++++++++
 tb/tb_burst_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/burst_pkg.sv
// Shared types and default widths for the burst controller.
package burst_pkg;

   localparam int unsigned WIDTH_DEF = 8;
   localparam int unsigned LEN_W_DEF = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } state_e;

endpackage

// File: rtl/burst_len_cnt.sv
// Remaining-beat down-counter: parallel load, saturating decrement, zero flag.
import burst_pkg::*;

module burst_len_cnt #(
   parameter int unsigned LEN_W = LEN_W_DEF
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             load_i,
   input  logic [LEN_W-1:0] load_val_i,
   input  logic             dec_i,
   output logic [LEN_W-1:0] cnt_o,
   output logic             zero_o
);

   logic [LEN_W-1:0] cnt_q;
   logic [LEN_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (dec_i && (cnt_q != '0)) begin
         // never step below zero
         cnt_d = cnt_q - LEN_W'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o  = cnt_q;
   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/burst_ctrl.sv
// Burst controller driving ld/inc strobes of a downstream loadable counter.
// Optional macro BURST_CTRL_STALL_EN adds a stall input that pauses RUN.
import burst_pkg::*;

module burst_ctrl #(
   parameter int unsigned WIDTH = WIDTH_DEF,
   parameter int unsigned LEN_W = LEN_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
`ifdef BURST_CTRL_STALL_EN
   input  logic             stall,
`endif
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [WIDTH-1:0] cmd_addr,
   input  logic [LEN_W-1:0] cmd_len,
   output logic             ld,
   output logic             inc,
   output logic [WIDTH-1:0] addr_out,
   output logic             busy,
   output logic             done
);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] addr_q;
   logic             ld_q, inc_q, done_q, busy_q, ready_q;
   logic [LEN_W-1:0] rem_s;
   logic             rem_zero_s;
   logic             accept_s, dec_s, last_s, stall_s;

`ifdef BURST_CTRL_STALL_EN
   assign stall_s = stall;
`else
   assign stall_s = 1'b0;
`endif

   assign accept_s = (state_q == IDLE) && cmd_valid;
   assign dec_s    = (state_q == LOAD) || ((state_q == RUN) && !stall_s);
   assign last_s   = (rem_s == LEN_W'(1)) || rem_zero_s;

   burst_len_cnt #(.LEN_W(LEN_W)) u_len_cnt (
      .clk_i      (clk),
      .rst_i      (rst),
      .load_i     (accept_s),
      .load_val_i (cmd_len),
      .dec_i      (dec_s),
      .cnt_o      (rem_s),
      .zero_o     (rem_zero_s)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               state_d = (cmd_len == '0) ? DONE : LOAD;
            end else begin
               state_d = IDLE;
            end
         end
         LOAD: state_d = last_s ? DONE : RUN;
         RUN: begin
            if (stall_s) begin
               state_d = RUN;
            end else if (last_s) begin
               state_d = DONE;
            end else begin
               state_d = RUN;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs are decoded from the next state so they line up with state_q.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         addr_q  <= '0;
         ld_q    <= 1'b0;
         inc_q   <= 1'b0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
         ready_q <= 1'b1;
      end else begin
         state_q <= state_d;
         ld_q    <= (state_d == LOAD);
         inc_q   <= (state_d == RUN);
         done_q  <= (state_d == DONE);
         busy_q  <= (state_d != IDLE);
         ready_q <= (state_d == IDLE);
         if (accept_s) begin
            addr_q <= cmd_addr;
         end else begin
            addr_q <= addr_q;
         end
      end
   end

   assign ld        = ld_q;
   assign done      = done_q;
   assign busy      = busy_q;
   assign cmd_ready = ready_q;
   assign addr_out  = addr_q;
`ifdef BURST_CTRL_STALL_EN
   // a stalled RUN cycle does not count as an increment beat
   assign inc = inc_q & ~stall;
`else
   assign inc = inc_q;
`endif

endmodule

// File: tb/tb_burst_ctrl.sv
// Directed scoreboard bench for burst_ctrl (stall test under BURST_CTRL_STALL_EN).
module tb_burst_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [7:0] cmd_addr;
   logic [3:0] cmd_len;
   logic       ld, inc, busy, done;
   logic [7:0] addr_out;
`ifdef BURST_CTRL_STALL_EN
   logic       stall;
`endif

   typedef struct {
      int addr;
      int len;
      int stall;
   } exp_t;

   exp_t sb[$];
   int   n_assert = 0;
   int   n_fail = 0;
   int   cyc = 0;
   int   total_beats = 0;
   int   ld_cnt = 0, inc_cnt = 0, busy_cnt = 0;

   always #5 clk = ~clk;

   burst_ctrl #(.WIDTH(8), .LEN_W(4)) dut (
      .clk       (clk),
      .rst       (rst),
`ifdef BURST_CTRL_STALL_EN
      .stall     (stall),
`endif
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_addr  (cmd_addr),
      .cmd_len   (cmd_len),
      .ld        (ld),
      .inc       (inc),
      .addr_out  (addr_out),
      .busy      (busy),
      .done      (done)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_assert++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic issue(input logic [7:0] a, input logic [3:0] l, input int st, output int t);
      bit ok = 1'b0;
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_addr  = a;
      cmd_len   = l;
      for (int i = 0; i < 100; i++) begin
         if (cmd_ready) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      chk("accept_timeout", ok, 1);
      if (ok) sb.push_back('{int'(a), int'(l), st});
      @(posedge clk);
      #1;
      t = cyc;
   endtask

   task automatic wait_idle();
      bit ok = 1'b0;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         if (cmd_ready && !busy) begin
            ok = 1'b1;
            break;
         end
      end
      chk("idle_timeout", ok, 1);
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Monitor: per-cycle invariants and scoreboard check on every done pulse.
   initial forever begin
      exp_t e;
      @(negedge clk);
      if (rst) begin
         ld_cnt = 0; inc_cnt = 0; busy_cnt = 0;
      end else begin
         if (busy) begin
            chk("ld_inc_excl", ld && inc, 0);
            busy_cnt++;
            if (ld) ld_cnt++;
            if (inc) inc_cnt++;
            total_beats += int'(ld) + int'(inc);
         end else begin
            chk("idle_no_strobe", {ld, inc, done}, 0);
         end
         chk("ready_vs_busy", cmd_ready, !busy);
         if (done) begin
            if (sb.size() == 0) begin
               chk("done_unexpected", 1, 0);
            end else begin
               e = sb.pop_front();
               chk("sb_ld_count", ld_cnt, (e.len > 0) ? 1 : 0);
               chk("sb_inc_count", inc_cnt, (e.len > 0) ? e.len - 1 : 0);
               chk("sb_busy_cycles", busy_cnt, e.len + 1 + e.stall);
               chk("sb_addr", addr_out, e.addr);
            end
            ld_cnt = 0; inc_cnt = 0; busy_cnt = 0;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int t1, t2, b0;
      rst = 1'b1; cmd_valid = 1'b0; cmd_addr = 8'h00; cmd_len = 4'h0;
`ifdef BURST_CTRL_STALL_EN
      stall = 1'b0;
`endif
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_strobes", {ld, inc, done, busy}, 0);
      chk("rst_ready", cmd_ready, 1);
      chk("rst_addr", addr_out, 8'h00);

      // addr 0x10, len 3
      issue(8'h10, 4'd3, 0, t1);
      @(negedge clk); cmd_valid = 1'b0;
      chk("a_ld", {ld, inc}, 2'b10);
      chk("a_addr", addr_out, 8'h10);
      chk("a_ready_low", cmd_ready, 0);
      @(negedge clk); chk("a_inc1", {ld, inc}, 2'b01);
      @(negedge clk); chk("a_inc2", {ld, inc}, 2'b01);
      @(negedge clk); chk("a_done", {done, inc}, 2'b10);
      @(negedge clk); chk("a_ready", {cmd_ready, done, busy}, 3'b100);

      // len 1 at the top address
      issue(8'hFF, 4'd1, 0, t1);
      @(negedge clk); cmd_valid = 1'b0;
      chk("b_ld", {ld, inc}, 2'b10);
      chk("b_addr", addr_out, 8'hFF);
      @(negedge clk); chk("b_done", {done, ld, inc}, 3'b100);
      wait_idle();

      // zero-length burst
      issue(8'h33, 4'd0, 0, t1);
      @(negedge clk); cmd_valid = 1'b0;
      chk("c_done", {done, busy, ld, inc}, 4'b1100);
      @(negedge clk); chk("c_idle", {busy, cmd_ready, done}, 3'b010);

      // back-to-back commands with cmd_valid held high
      b0 = total_beats;
      issue(8'h20, 4'd2, 0, t1);
      issue(8'h30, 4'd1, 0, t2);
      @(negedge clk); cmd_valid = 1'b0;
      chk("d_accept_gap", t2 - t1, 4);
      wait_idle();
      chk("d_total_beats", total_beats - b0, 3);

      // reset in the middle of a long burst
      issue(8'h40, 4'd15, 0, t1);
      @(negedge clk); cmd_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("e_running", inc, 1);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      sb.delete();
      @(negedge clk);
      chk("e_strobes", {ld, inc, done, busy}, 0);
      chk("e_ready", cmd_ready, 1);
      chk("e_addr", addr_out, 8'h00);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("e_no_done", done, 0);
      end

      // recovery after reset
      issue(8'h55, 4'd2, 0, t1);
      @(negedge clk); cmd_valid = 1'b0;
      wait_idle();

`ifdef BURST_CTRL_STALL_EN
      // len 4 with a two-cycle stall after the first increment
      issue(8'h66, 4'd4, 2, t1);
      @(negedge clk); cmd_valid = 1'b0;
      @(negedge clk); chk("f_inc1", inc, 1);
      @(posedge clk); #1 stall = 1'b1;
      @(negedge clk); chk("f_stall1", {inc, busy}, 2'b01);
      @(posedge clk); #1;
      @(negedge clk); chk("f_stall2", {inc, busy}, 2'b01);
      @(posedge clk); #1 stall = 1'b0;
      wait_idle();
`endif

      repeat (2) @(negedge clk);
      chk("sb_empty", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
